// File: rtl/ab_req_data_merge_if.sv
`default_nettype none
// ============================================================================
// Module      : ab_req_data_merge_if
// Description : Bundle of the channel A request, channel B data and merged
//               output signals of the A/B request-data merger.
//               slave  - merger view (requests/data in, beats out)
//               master - driver/consumer view (the opposite directions)
// Ports       : Valid_Addr/Address/Length/Addr_Ready       channel A request
//               Valid_Data/Data/Data_Ready                  channel B data
//               Out_Valid/Out_Ready/Out_Addr/Out_Data/Out_Last  beat stream
//               Err_Orphan, Pending_Count                   status
// Revision    : 1.0 - initial release
// ============================================================================
interface ab_req_data_merge_if #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 4,
    parameter int DATA_W = 24,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              Valid_Addr;
    logic [ADDR_W-1:0] Address;
    logic [LEN_W-1:0]  Length;
    logic              Addr_Ready;
    logic              Valid_Data;
    logic [DATA_W-1:0] Data;
    logic              Data_Ready;
    logic              Out_Valid;
    logic              Out_Ready;
    logic [ADDR_W-1:0] Out_Addr;
    logic [DATA_W-1:0] Out_Data;
    logic              Out_Last;
    logic              Err_Orphan;
    logic [CNT_W-1:0]  Pending_Count;

    modport slave (
        input  Valid_Addr, Address, Length, Valid_Data, Data, Out_Ready,
        output Addr_Ready, Data_Ready, Out_Valid, Out_Addr, Out_Data,
               Out_Last, Err_Orphan, Pending_Count
    );

    modport master (
        output Valid_Addr, Address, Length, Valid_Data, Data, Out_Ready,
        input  Addr_Ready, Data_Ready, Out_Valid, Out_Addr, Out_Data,
               Out_Last, Err_Orphan, Pending_Count
    );
endinterface
`default_nettype wire

// File: rtl/ab_req_data_merge.sv
`default_nettype none
// ============================================================================
// Module      : ab_req_data_merge
// Description : Queues channel A burst requests {Address, Length} in a small
//               FIFO and pairs the head request with Length+1 channel B data
//               beats, producing a per-beat stream carrying the beat address
//               (base + beat index, wrapping) and a last-beat marker.
//               Data arriving with no queued request is dropped and flagged.
// Ports       : clk  - clock, all state on rising edge
//               rst  - synchronous active-high reset
//               bus  - ab_req_data_merge_if.slave (request, data, output
//                      stream, Err_Orphan pulse, Pending_Count occupancy)
// Revision    : 1.0 - initial release
// ============================================================================
module ab_req_data_merge #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 4,
    parameter int DATA_W = 24,
    parameter int DEPTH  = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    ab_req_data_merge_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Request FIFO storage (no reset needed: only read when count != 0)
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [LEN_W-1:0]  len_mem_q  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              err_orphan_q, err_orphan_d;

    logic              w_full;
    logic              w_empty;
    logic              w_addr_ready;
    logic              w_data_ready;
    logic              w_push;
    logic              w_data_acc;
    logic              w_is_last;
    logic              w_pop;
    logic [ADDR_W-1:0] w_head_addr;
    logic [LEN_W-1:0]  w_head_len;
    logic [ADDR_W-1:0] w_beat_off;

    assign w_full  = (count_q == CNT_W'(DEPTH));
    assign w_empty = (count_q == '0);

    // Readiness is suppressed during reset; full does not anticipate a pop.
    assign w_addr_ready = !rst && !w_full;
    assign w_data_ready = !rst && !w_empty && (!out_valid_q || bus.Out_Ready);

    assign w_push     = bus.Valid_Addr && w_addr_ready;
    assign w_data_acc = bus.Valid_Data && w_data_ready;

    assign w_head_addr = addr_mem_q[rd_ptr_q];
    assign w_head_len  = len_mem_q[rd_ptr_q];
    assign w_beat_off  = ADDR_W'(beat_cnt_q);
    assign w_is_last   = (beat_cnt_q == w_head_len);
    assign w_pop       = w_data_acc && w_is_last;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        beat_cnt_d   = beat_cnt_q;
        out_valid_d  = out_valid_q;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        // The check uses the registered count, so a request pushed in the
        // same cycle does not rescue the beat.
        err_orphan_d = bus.Valid_Data && w_empty;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (w_push && !w_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - CNT_W'(1);
        end

        if (w_data_acc) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.Data;
            out_addr_d  = w_head_addr + w_beat_off;   // wraps modulo 2^ADDR_W
            out_last_d  = w_is_last;
            beat_cnt_d  = w_is_last ? '0 : beat_cnt_q + LEN_W'(1);
        end else if (bus.Out_Ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            beat_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            beat_cnt_q   <= beat_cnt_d;
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            addr_mem_q[wr_ptr_q] <= bus.Address;
            len_mem_q[wr_ptr_q]  <= bus.Length;
        end
    end

    assign bus.Addr_Ready    = w_addr_ready;
    assign bus.Data_Ready    = w_data_ready;
    assign bus.Out_Valid     = out_valid_q;
    assign bus.Out_Addr      = out_addr_q;
    assign bus.Out_Data      = out_data_q;
    assign bus.Out_Last      = out_last_q;
    assign bus.Err_Orphan    = err_orphan_q;
    assign bus.Pending_Count = count_q;
endmodule
`default_nettype wire

// File: tb/tb_ab_req_data_merge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ab_req_data_merge
// Description : Directed self-checking bench for ab_req_data_merge.
//               Inputs change 2 time units after the rising edge; registered
//               outputs are sampled there, combinational readies 1 unit later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ab_req_data_merge;
    localparam int ADDR_W = 12;
    localparam int LEN_W  = 4;
    localparam int DATA_W = 24;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ab_req_data_merge_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    ab_req_data_merge #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.Valid_Addr = 1'b0;
        bus.Address    = '0;
        bus.Length     = '0;
        bus.Valid_Data = 1'b0;
        bus.Data       = '0;
        bus.Out_Ready  = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        #1;
        n_chk++; if (bus.Addr_Ready !== 1'b0) begin n_fail++; $display("FAIL reset_addr_ready: got %0h want 0", bus.Addr_Ready); end
        n_chk++; if (bus.Data_Ready !== 1'b0) begin n_fail++; $display("FAIL reset_data_ready: got %0h want 0", bus.Data_Ready); end
        n_chk++; if (bus.Out_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0h want 0", bus.Out_Valid); end
        n_chk++; if (bus.Out_Addr !== 12'h000) begin n_fail++; $display("FAIL reset_out_addr: got %0h want 0", bus.Out_Addr); end
        n_chk++; if (bus.Out_Data !== 24'h000000) begin n_fail++; $display("FAIL reset_out_data: got %0h want 0", bus.Out_Data); end
        n_chk++; if (bus.Out_Last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %0h want 0", bus.Out_Last); end
        n_chk++; if (bus.Err_Orphan !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0h want 0", bus.Err_Orphan); end
        n_chk++; if (bus.Pending_Count !== 3'd0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", bus.Pending_Count); end
        rst = 1'b0;
        #1;
        n_chk++; if (bus.Addr_Ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_addr_ready: got %0h want 1", bus.Addr_Ready); end
        n_chk++; if (bus.Data_Ready !== 1'b0) begin n_fail++; $display("FAIL post_reset_data_ready: got %0h want 0", bus.Data_Ready); end
        step();
    endtask

    task automatic test_single_beat();
        bus.Valid_Addr = 1'b1; bus.Address = 12'h100; bus.Length = 4'd0;
        step();
        bus.Valid_Addr = 1'b0;
        n_chk++; if (bus.Pending_Count !== 3'd1) begin n_fail++; $display("FAIL single_pending1: got %0d want 1", bus.Pending_Count); end
        bus.Valid_Data = 1'b1; bus.Data = 24'hABCDEF;
        #1;
        n_chk++; if (bus.Data_Ready !== 1'b1) begin n_fail++; $display("FAIL single_data_ready: got %0h want 1", bus.Data_Ready); end
        step();
        bus.Valid_Data = 1'b0;
        n_chk++; if (bus.Out_Valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0h want 1", bus.Out_Valid); end
        n_chk++; if (bus.Out_Addr !== 12'h100) begin n_fail++; $display("FAIL single_addr: got %0h want 100", bus.Out_Addr); end
        n_chk++; if (bus.Out_Data !== 24'hABCDEF) begin n_fail++; $display("FAIL single_data: got %0h want abcdef", bus.Out_Data); end
        n_chk++; if (bus.Out_Last !== 1'b1) begin n_fail++; $display("FAIL single_last: got %0h want 1", bus.Out_Last); end
        n_chk++; if (bus.Pending_Count !== 3'd0) begin n_fail++; $display("FAIL single_pending0: got %0d want 0", bus.Pending_Count); end
        step();
        n_chk++; if (bus.Out_Valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_clear: got %0h want 0", bus.Out_Valid); end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] exp_addr [4];
        logic [DATA_W-1:0] dat [4];
        exp_addr[0] = 12'hFFE; exp_addr[1] = 12'hFFF; exp_addr[2] = 12'h000; exp_addr[3] = 12'h001;
        dat[0] = 24'h111111; dat[1] = 24'h222222; dat[2] = 24'h333333; dat[3] = 24'h444444;
        bus.Valid_Addr = 1'b1; bus.Address = 12'hFFE; bus.Length = 4'd3;
        step();
        bus.Valid_Addr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.Valid_Data = 1'b1; bus.Data = dat[k];
            step();
            n_chk++; if (bus.Out_Addr !== exp_addr[k]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0h want %0h", k, bus.Out_Addr, exp_addr[k]); end
            n_chk++; if (bus.Out_Data !== dat[k]) begin n_fail++; $display("FAIL wrap_data[%0d]: got %0h want %0h", k, bus.Out_Data, dat[k]); end
            n_chk++; if (bus.Out_Last !== (k == 3)) begin n_fail++; $display("FAIL wrap_last[%0d]: got %0h want %0h", k, bus.Out_Last, (k == 3)); end
        end
        bus.Valid_Data = 1'b0;
        step();
        n_chk++; if (bus.Out_Valid !== 1'b0) begin n_fail++; $display("FAIL wrap_valid_clear: got %0h want 0", bus.Out_Valid); end
        n_chk++; if (bus.Pending_Count !== 3'd0) begin n_fail++; $display("FAIL wrap_pending: got %0d want 0", bus.Pending_Count); end
    endtask

    task automatic test_full();
        logic [ADDR_W-1:0] drain_addr [7];
        drain_addr[0] = 12'h210; drain_addr[1] = 12'h211; drain_addr[2] = 12'h220; drain_addr[3] = 12'h221;
        drain_addr[4] = 12'h230; drain_addr[5] = 12'h231; drain_addr[6] = 12'h240;
        for (int k = 0; k < 4; k++) begin
            bus.Valid_Addr = 1'b1; bus.Address = 12'h200 + 12'(k * 16); bus.Length = 4'd1;
            step();
        end
        // fifth request held while the FIFO is full
        bus.Address = 12'h240; bus.Length = 4'd0;
        #1;
        n_chk++; if (bus.Pending_Count !== 3'd4) begin n_fail++; $display("FAIL full_pending4: got %0d want 4", bus.Pending_Count); end
        n_chk++; if (bus.Addr_Ready !== 1'b0) begin n_fail++; $display("FAIL full_addr_ready: got %0h want 0", bus.Addr_Ready); end
        bus.Valid_Data = 1'b1; bus.Data = 24'h0000A0;
        step();
        n_chk++; if (bus.Addr_Ready !== 1'b0) begin n_fail++; $display("FAIL full_still_full: got %0h want 0", bus.Addr_Ready); end
        bus.Data = 24'h0000A1;
        step();
        // last beat of head burst accepted at the previous edge
        n_chk++; if (bus.Out_Addr !== 12'h201 || bus.Out_Last !== 1'b1) begin n_fail++; $display("FAIL full_head_last: got addr %0h last %0h want 201/1", bus.Out_Addr, bus.Out_Last); end
        n_chk++; if (bus.Pending_Count !== 3'd3) begin n_fail++; $display("FAIL full_pending3: got %0d want 3", bus.Pending_Count); end
        n_chk++; if (bus.Addr_Ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_return: got %0h want 1", bus.Addr_Ready); end
        bus.Valid_Data = 1'b0;
        step();
        bus.Valid_Addr = 1'b0;
        n_chk++; if (bus.Pending_Count !== 3'd4) begin n_fail++; $display("FAIL full_fifth_pushed: got %0d want 4", bus.Pending_Count); end
        for (int k = 0; k < 7; k++) begin
            bus.Valid_Data = 1'b1; bus.Data = 24'h0000B0 + 24'(k);
            step();
            n_chk++; if (bus.Out_Valid !== 1'b1 || bus.Out_Addr !== drain_addr[k]) begin n_fail++; $display("FAIL full_drain_addr[%0d]: got v%0h %0h want v1 %0h", k, bus.Out_Valid, bus.Out_Addr, drain_addr[k]); end
        end
        n_chk++; if (bus.Out_Last !== 1'b1) begin n_fail++; $display("FAIL full_drain_last: got %0h want 1", bus.Out_Last); end
        n_chk++; if (bus.Pending_Count !== 3'd0) begin n_fail++; $display("FAIL full_drain_pending: got %0d want 0", bus.Pending_Count); end
        bus.Valid_Data = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        bus.Valid_Addr = 1'b1; bus.Address = 12'h300; bus.Length = 4'd2;
        step();
        bus.Valid_Addr = 1'b0;
        bus.Out_Ready = 1'b0; bus.Valid_Data = 1'b1; bus.Data = 24'hB00000;
        step();
        bus.Data = 24'hB11111;
        #1;
        n_chk++; if (bus.Data_Ready !== 1'b0) begin n_fail++; $display("FAIL bp_data_ready: got %0h want 0", bus.Data_Ready); end
        step();
        step();
        n_chk++; if (bus.Out_Valid !== 1'b1 || bus.Out_Data !== 24'hB00000 || bus.Out_Addr !== 12'h300) begin n_fail++; $display("FAIL bp_hold: got v%0h %0h @%0h want v1 b00000 @300", bus.Out_Valid, bus.Out_Data, bus.Out_Addr); end
        n_chk++; if (bus.Pending_Count !== 3'd1) begin n_fail++; $display("FAIL bp_pending: got %0d want 1", bus.Pending_Count); end
        bus.Out_Ready = 1'b1;
        #1;
        n_chk++; if (bus.Data_Ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_return: got %0h want 1", bus.Data_Ready); end
        step();
        n_chk++; if (bus.Out_Data !== 24'hB11111 || bus.Out_Addr !== 12'h301 || bus.Out_Last !== 1'b0) begin n_fail++; $display("FAIL bp_beat1: got %0h @%0h l%0h want b11111 @301 l0", bus.Out_Data, bus.Out_Addr, bus.Out_Last); end
        bus.Data = 24'hB22222;
        step();
        bus.Valid_Data = 1'b0;
        n_chk++; if (bus.Out_Data !== 24'hB22222 || bus.Out_Addr !== 12'h302 || bus.Out_Last !== 1'b1) begin n_fail++; $display("FAIL bp_beat2: got %0h @%0h l%0h want b22222 @302 l1", bus.Out_Data, bus.Out_Addr, bus.Out_Last); end
        step();
        n_chk++; if (bus.Out_Valid !== 1'b0 || bus.Pending_Count !== 3'd0) begin n_fail++; $display("FAIL bp_done: got v%0h p%0d want v0 p0", bus.Out_Valid, bus.Pending_Count); end
    endtask

    task automatic test_orphan();
        bus.Valid_Data = 1'b1; bus.Data = 24'h123456;
        step();
        bus.Valid_Data = 1'b0;
        n_chk++; if (bus.Err_Orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_pulse: got %0h want 1", bus.Err_Orphan); end
        n_chk++; if (bus.Out_Valid !== 1'b0) begin n_fail++; $display("FAIL orphan_no_valid: got %0h want 0", bus.Out_Valid); end
        step();
        n_chk++; if (bus.Err_Orphan !== 1'b0) begin n_fail++; $display("FAIL orphan_pulse_end: got %0h want 0", bus.Err_Orphan); end
        bus.Valid_Data = 1'b1; bus.Data = 24'h123456;
        bus.Valid_Addr = 1'b1; bus.Address = 12'h400; bus.Length = 4'd0;
        step();
        bus.Valid_Data = 1'b0; bus.Valid_Addr = 1'b0;
        n_chk++; if (bus.Err_Orphan !== 1'b1 || bus.Out_Valid !== 1'b0) begin n_fail++; $display("FAIL orphan_push_pulse: got e%0h v%0h want e1 v0", bus.Err_Orphan, bus.Out_Valid); end
        n_chk++; if (bus.Pending_Count !== 3'd1) begin n_fail++; $display("FAIL orphan_push_queued: got %0d want 1", bus.Pending_Count); end
        step();
        n_chk++; if (bus.Err_Orphan !== 1'b0) begin n_fail++; $display("FAIL orphan_push_end: got %0h want 0", bus.Err_Orphan); end
        bus.Valid_Data = 1'b1; bus.Data = 24'h654321;
        step();
        bus.Valid_Data = 1'b0;
        n_chk++; if (bus.Out_Addr !== 12'h400 || bus.Out_Data !== 24'h654321 || bus.Out_Last !== 1'b1) begin n_fail++; $display("FAIL orphan_drain: got %0h @%0h l%0h want 654321 @400 l1", bus.Out_Data, bus.Out_Addr, bus.Out_Last); end
        step();
    endtask

    task automatic test_reset_mid_burst();
        bus.Valid_Addr = 1'b1; bus.Address = 12'h500; bus.Length = 4'd7;
        step();
        bus.Address = 12'h600; bus.Length = 4'd0;
        step();
        bus.Valid_Addr = 1'b0;
        bus.Valid_Data = 1'b1; bus.Data = 24'hC00000;
        step();
        bus.Data = 24'hC11111;
        step();
        bus.Valid_Data = 1'b0;
        n_chk++; if (bus.Out_Addr !== 12'h501 || bus.Pending_Count !== 3'd2) begin n_fail++; $display("FAIL mid_before: got @%0h p%0d want @501 p2", bus.Out_Addr, bus.Pending_Count); end
        rst = 1'b1;
        #1;
        n_chk++; if (bus.Addr_Ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_addr_ready: got %0h want 0", bus.Addr_Ready); end
        step();
        n_chk++; if (bus.Out_Valid !== 1'b0 || bus.Out_Addr !== 12'h000 || bus.Out_Data !== 24'h000000 || bus.Out_Last !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out: got v%0h @%0h %0h l%0h want all 0", bus.Out_Valid, bus.Out_Addr, bus.Out_Data, bus.Out_Last); end
        n_chk++; if (bus.Pending_Count !== 3'd0 || bus.Err_Orphan !== 1'b0) begin n_fail++; $display("FAIL mid_rst_state: got p%0d e%0h want p0 e0", bus.Pending_Count, bus.Err_Orphan); end
        rst = 1'b0;
        bus.Valid_Addr = 1'b1; bus.Address = 12'h700; bus.Length = 4'd0;
        step();
        bus.Valid_Addr = 1'b0;
        bus.Valid_Data = 1'b1; bus.Data = 24'h0A0B0C;
        step();
        bus.Valid_Data = 1'b0;
        n_chk++; if (bus.Out_Valid !== 1'b1 || bus.Out_Addr !== 12'h700 || bus.Out_Data !== 24'h0A0B0C || bus.Out_Last !== 1'b1) begin n_fail++; $display("FAIL mid_after: got v%0h @%0h %0h l%0h want v1 @700 0a0b0c l1", bus.Out_Valid, bus.Out_Addr, bus.Out_Data, bus.Out_Last); end
        n_chk++; if (bus.Pending_Count !== 3'd0) begin n_fail++; $display("FAIL mid_after_pending: got %0d want 0", bus.Pending_Count); end
        step();
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_wrap();
        test_full();
        test_backpressure();
        test_orphan();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
